// File: rtl/inst_classifier_pkg.sv
// Opcode classes, immediate formats and major-opcode constants shared by
// the instruction classifier and its immediate generator.
package opcode_type;

  typedef enum logic [3:0] {
    invalid,
    lui_type,
    auipc_type,
    jal_type,
    jalr_type,
    branch_type,
    load_type,
    store_type,
    imm_arith_type,
    reg_arith_type,
    misc_mem_type,
    system_type,
    imm_arith_w_type,
    reg_arith_w_type
  } opcode_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/inst_classifier_imm_gen.sv
// Combinational immediate generator: assembles the sign-extended immediate
// for the selected instruction format; inst[31] is always the sign bit.
module imm_gen
  import opcode_type::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
      IMM_S: imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
      IMM_B: imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_classifier.sv
// Pipelined opcode classifier between fetch and register-read: decodes one
// instruction per cycle into a main output register backed by one skid entry.
module inst_classifier
  import opcode_type::*;
#(
  parameter int XLEN         = 32,
  parameter int ENABLE_M     = 0,
  parameter int ENABLE_ZICSR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output opcode_t         out_opcode_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    opcode_t         opc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } dec_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [6:0]      sh_hi;
  logic            sh_ok, sh_w_ok, f7_ok;
  opcode_t         cls;
  imm_fmt_t        fmt;
  logic            bad, illegal;
  logic [XLEN-1:0] imm;
  dec_t            dec, main_q, skid_q;
  logic            out_valid_q, skid_valid, in_ready_q;
  logic            accept, advance;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  // RV64 shift-immediates use a 6-bit shamt, so only inst[31:26] is checked
  assign sh_hi   = (XLEN == 64) ? {in_inst[31:26], 1'b0} : f7;
  assign sh_ok   = (f3 != 3'b001 && f3 != 3'b101) || (sh_hi == 7'b0) ||
                   (f3 == 3'b101 && sh_hi == 7'b0100000);
  assign sh_w_ok = (f3 != 3'b001 && f3 != 3'b101) || (f7 == 7'b0) ||
                   (f3 == 3'b101 && f7 == 7'b0100000);
  assign f7_ok   = (f7 == 7'b0) ||
                   (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                   (ENABLE_M != 0 && f7 == 7'b0000001);

  always_comb begin
    cls = invalid;
    fmt = IMM_NONE;
    bad = 1'b0;
    case (opc)
      OPC_LUI:      begin cls = lui_type;       fmt = IMM_U; end
      OPC_AUIPC:    begin cls = auipc_type;     fmt = IMM_U; end
      OPC_JAL:      begin cls = jal_type;       fmt = IMM_J; end
      OPC_JALR:     begin cls = jalr_type;      fmt = IMM_I; end
      OPC_BRANCH:   begin cls = branch_type;    fmt = IMM_B; end
      OPC_LOAD:     begin cls = load_type;      fmt = IMM_I; end
      OPC_STORE:    begin cls = store_type;     fmt = IMM_S; end
      OPC_OP_IMM:   begin cls = imm_arith_type; fmt = IMM_I; bad = !sh_ok; end
      OPC_OP:       begin cls = reg_arith_type; bad = !f7_ok; end
      OPC_MISC_MEM: cls = misc_mem_type;
      OPC_SYSTEM: begin
        cls = system_type;
        fmt = IMM_I;
        bad = (ENABLE_ZICSR == 0) && (in_inst != 32'h0000_0073) && (in_inst != 32'h0010_0073);
      end
      OPC_OP_IMM_32: if (XLEN == 64) begin cls = imm_arith_w_type; fmt = IMM_I; bad = !sh_w_ok; end
      OPC_OP_32:     if (XLEN == 64) begin cls = reg_arith_w_type; bad = !f7_ok; end
      default: ;
    endcase
    illegal = bad || (cls == invalid) || (in_inst[1:0] != 2'b11);
    if (illegal) cls = invalid;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst(in_inst),
    .fmt (fmt),
    .imm (imm)
  );

  always_comb begin
    dec         = '0;
    dec.opc     = cls;
    dec.rd      = in_inst[11:7];
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.f3      = f3;
    dec.f7      = f7;
    dec.imm     = imm;
    dec.illegal = illegal;
    dec.pc      = in_pc;
  end

  assign accept  = in_valid && in_ready_q;
  assign advance = !out_valid_q || out_ready;

  // Skid entry drains into main before any new input; in_ready mirrors skid-empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (advance) begin
      if (skid_valid) begin
        main_q      <= skid_q;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        out_valid_q <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_opcode_type = main_q.opc;
  assign out_rd          = main_q.rd;
  assign out_rs1         = main_q.rs1;
  assign out_rs2         = main_q.rs2;
  assign out_funct3      = main_q.f3;
  assign out_funct7      = main_q.f7;
  assign out_imm         = main_q.imm;
  assign out_illegal     = main_q.illegal;
  assign out_pc          = main_q.pc;

endmodule

// File: tb/tb_inst_classifier.sv
// Scoreboard bench for inst_classifier: decode vectors, streaming, skid stall,
// flush and asynchronous reset, plus an ENABLE_M=1 instance for M-extension legality.
module tb_inst_classifier;
  import opcode_type::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0]     in_inst = '0;
  logic [XLEN-1:0] in_pc = '0;

  logic            in_ready, out_valid, out_illegal;
  opcode_t         out_opcode_type;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm, out_pc;

  logic            m_in_ready, m_out_valid, m_illegal;
  opcode_t         m_opcode_type;
  logic [4:0]      m_rd, m_rs1, m_rs2;
  logic [2:0]      m_funct3;
  logic [6:0]      m_funct7;
  logic [XLEN-1:0] m_imm, m_pc;

  inst_classifier #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode_type(out_opcode_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_illegal(out_illegal), .out_pc(out_pc)
  );

  inst_classifier #(.XLEN(XLEN), .ENABLE_M(1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_opcode_type(m_opcode_type), .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
    .out_funct3(m_funct3), .out_funct7(m_funct7), .out_imm(m_imm),
    .out_illegal(m_illegal), .out_pc(m_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    opcode_t         opc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [XLEN-1:0] imm;
    logic            ill;
    logic [XLEN-1:0] pc;
  } exp_t;

  typedef struct packed {
    logic [31:0]     inst;
    opcode_t         opc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [XLEN-1:0] imm;
    logic            ill;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0, failures = 0;

  function automatic exp_t observed();
    return '{out_opcode_type, out_rd, out_rs1, out_imm, out_illegal, out_pc};
  endfunction

  function automatic exp_t expect_of(input int i, input logic [XLEN-1:0] pc);
    return '{vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].imm, vecs[i].ill, pc};
  endfunction

  task automatic test_reset();
    exp_t z;
    z = '{invalid, 5'd0, 5'd0, '0, 1'b0, '0};
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_hs[%0d] got valid=%b ready=%b exp valid=0 ready=1", k, out_valid, in_ready);
      end
      checks++;
      if (observed() !== z || {out_rs2, out_funct3, out_funct7} !== 15'd0) begin
        failures++;
        $display("FAIL reset_fields[%0d] got=%h exp=%h", k, observed(), z);
      end
      if (k == 0) begin
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_decode();
    exp_t e, a;
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1;
      in_inst  = vecs[i].inst;
      in_pc    = 32'h1000 + 32'(4 * i);
      sb.push_back(expect_of(i, in_pc));
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL decode_latency[%0d] got out_valid=%b exp 1", i, out_valid);
      end
      e = sb.pop_front();
      a = observed();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL decode[%08h] got=%h exp=%h", vecs[i].inst, a, e);
      end
      if (vecs[i].inst == 32'h0220_8033) begin
        checks++;
        if (m_opcode_type !== reg_arith_type || m_illegal !== 1'b0 || m_rs2 !== 5'd2 || m_funct7 !== 7'd1) begin
          failures++;
          $display("FAIL mul_enable_m got type=%0d ill=%b rs2=%0d f7=%h exp type=%0d ill=0 rs2=2 f7=01",
                   m_opcode_type, m_illegal, m_rs2, m_funct7, reg_arith_type);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    exp_t e, a;
    out_ready = 1'b1;
    while (got < vecs.size() && cyc < 100) begin
      in_valid = (sent < vecs.size());
      if (in_valid) begin
        in_inst = vecs[sent].inst;
        in_pc   = 32'h2000 + 32'(4 * sent);
      end
      if (cyc > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_bubble[%0d] got out_valid=%b exp 1", cyc, out_valid);
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        a = observed();
        got++;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL b2b[%0d] got=%h exp=%h", got - 1, a, e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(expect_of(sent, in_pc));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != vecs.size()) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d exp=%0d", got, vecs.size());
    end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, cyc = 0;
    exp_t e, a;
    out_ready = 1'b0;
    while (got < 4 && cyc < 60) begin
      if (cyc == 6) out_ready = 1'b1;
      in_valid = (sent < 4);
      if (in_valid) begin
        in_inst = vecs[sent].inst;
        in_pc   = 32'h3000 + 32'(4 * sent);
      end
      if (cyc == 3) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2 || out_valid !== 1'b1 || out_pc !== 32'h3000) begin
          failures++;
          $display("FAIL stall_hold got ready=%b accepted=%0d valid=%b pc=%h exp ready=0 accepted=2 valid=1 pc=00003000",
                   in_ready, sent, out_valid, out_pc);
        end
      end
      if (out_valid && out_ready) begin
        a = observed();
        got++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stall_extra got=%h exp none", a);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL stall_order[%0d] got=%h exp=%h", got - 1, a, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(expect_of(sent, in_pc));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got out=%0d left=%0d valid=%b exp out=4 left=0 valid=0", got, sb.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    exp_t e, a;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_inst  = vecs[k].inst;
      in_pc    = 32'h4000 + 32'(4 * k);
      @(negedge clk);
    end
    flush   = 1'b1;
    in_inst = vecs[2].inst;
    in_pc   = 32'h4008;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_leak got out_valid=%b pc=%h exp 0", out_valid, out_pc);
    end
    // flush while in_ready is high must still drop the input
    in_valid = 1'b1;
    in_inst  = vecs[4].inst;
    in_pc    = 32'h4010;
    flush    = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
    in_inst = vecs[3].inst;
    in_pc   = 32'h400C;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_accept got out_valid=%b pc=%h exp 0", out_valid, out_pc);
    end
    sb.push_back(expect_of(3, in_pc));
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    a = observed();
    checks++;
    if (out_valid !== 1'b1 || a !== e) begin
      failures++;
      $display("FAIL flush_resume got valid=%b %h exp valid=1 %h", out_valid, a, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e, a, z;
    z = '{invalid, 5'd0, 5'd0, '0, 1'b0, '0};
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_inst  = vecs[k].inst;
      in_pc    = 32'h5000 + 32'(4 * k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== z) begin
      failures++;
      $display("FAIL reset_async got valid=%b ready=%b %h exp valid=0 ready=1 %h", out_valid, in_ready, observed(), z);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = vecs[2].inst;
    in_pc     = 32'h5100;
    sb.push_back(expect_of(2, in_pc));
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    a = observed();
    checks++;
    if (out_valid !== 1'b1 || a !== e) begin
      failures++;
      $display("FAIL reset_resume got valid=%b %h exp valid=1 %h", out_valid, a, e);
    end
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{32'h0050_0093, imm_arith_type, 5'd1,  5'd0, 32'h0000_0005, 1'b0});
    vecs.push_back('{32'hFFF0_0093, imm_arith_type, 5'd1,  5'd0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'h1234_50B7, lui_type,       5'd1,  5'd8, 32'h1234_5000, 1'b0});
    vecs.push_back('{32'hFE00_0EE3, branch_type,    5'd29, 5'd0, 32'hFFFF_FFFC, 1'b0});
    vecs.push_back('{32'h0000_0000, invalid,        5'd0,  5'd0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0220_8033, invalid,        5'd0,  5'd1, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0011_2223, store_type,     5'd4,  5'd2, 32'h0000_0004, 1'b0});
    vecs.push_back('{32'h0080_00EF, jal_type,       5'd1,  5'd0, 32'h0000_0008, 1'b0});
    vecs.push_back('{32'h4010_D093, imm_arith_type, 5'd1,  5'd1, 32'h0000_0401, 1'b0});
    vecs.push_back('{32'h4010_9093, invalid,        5'd1,  5'd1, 32'h0000_0401, 1'b1});
    vecs.push_back('{32'h0000_0073, system_type,    5'd0,  5'd0, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h4020_8033, reg_arith_type, 5'd0,  5'd1, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0001, invalid,        5'd0,  5'd0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0FF0_000F, misc_mem_type,  5'd0,  5'd0, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h00C0_8067, jalr_type,      5'd0,  5'd1, 32'h0000_000C, 1'b0});
    vecs.push_back('{32'h0001_7197, auipc_type,     5'd3,  5'd2, 32'h0001_7000, 1'b0});
    vecs.push_back('{32'hFFC1_2083, load_type,      5'd1,  5'd2, 32'hFFFF_FFFC, 1'b0});

    repeat (2) @(negedge clk);
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
